// File: rtl/gpu_sprite_engine.sv
// 1-bit framebuffer sprite engine: row-per-cycle CLEAR and XOR sprite DRAW with
// collision detection, fetching sprite bytes from a one-cycle-latency memory.
module gpu_sprite_engine #(
    parameter int unsigned FB_WIDTH   = 64,
    parameter int unsigned FB_HEIGHT  = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned WRAP       = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   gpu_cmd,
    input  logic [ADDR_WIDTH-1:0]        gpu_draw_offset,
    input  logic [7:0]                   gpu_draw_x,
    input  logic [7:0]                   gpu_draw_y,
    input  logic [7:0]                   gpu_draw_length,
    input  logic                         gpu_cmd_submitted,
    output logic                         gpu_ready,
    output logic                         gpu_done,
    output logic                         gpu_collision,
    output logic                         gpu_error,
    output logic                         mem_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [7:0]                   mem_rdata,
    input  logic [$clog2(FB_WIDTH)-1:0]  fb_rd_x,
    input  logic [$clog2(FB_HEIGHT)-1:0] fb_rd_y,
    output logic                         fb_rd_pixel
);
    localparam int unsigned XW   = $clog2(FB_WIDTH);
    localparam int unsigned YW   = $clog2(FB_HEIGHT);
    localparam int unsigned CNTW = (YW > 8) ? YW : 8;
    localparam int unsigned CW   = XW + 1;
    localparam int unsigned RW   = CNTW + 1;
    localparam logic [3:0]  CMD_CLEAR = 4'h1;
    localparam logic [3:0]  CMD_DRAW  = 4'h2;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_WRITE} state_t;

    state_t              state, state_nx;
    logic                done_nx;
    logic [CNTW-1:0]     cnt;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [7:0]          len_q;
    logic [7:0]          byte_q;
    logic [FB_WIDTH-1:0] fb [FB_HEIGHT];
    logic [FB_WIDTH-1:0] wr_mask;
    logic [CW-1:0]       col_sum;
    logic [RW-1:0]       row_sum;
    logic [YW-1:0]       row_idx;
    logic                row_ok;
    logic                hit;

    assign gpu_ready   = (state == S_IDLE);
    assign mem_rd      = (state == S_FETCH);
    assign fb_rd_pixel = fb[fb_rd_y][fb_rd_x];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // cnt counts rows: cleared row during CLEAR, sprite row index during DRAW
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (gpu_cmd_submitted) begin
                    if (gpu_cmd == CMD_CLEAR)
                        state_nx = S_CLEAR;
                    else if (gpu_cmd == CMD_DRAW && gpu_draw_length != 8'd0)
                        state_nx = S_FETCH;
                    else
                        done_nx = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt == CNTW'(FB_HEIGHT - 1)) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            S_FETCH: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_WRITE;
            S_WRITE: begin
                if (cnt + CNTW'(1) == CNTW'(len_q)) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sprite byte placed on the target row; off-screen bits either wrap or drop
    always_comb begin
        wr_mask = '0;
        col_sum = '0;
        for (int k = 0; k < 8; k++) begin
            col_sum = CW'(x_q) + CW'(k);
            if (byte_q[3'(7 - k)] && (WRAP != 0 || col_sum < CW'(FB_WIDTH)))
                wr_mask[XW'(col_sum)] = 1'b1;
        end
        row_sum = RW'(y_q) + RW'(cnt);
        row_ok  = (WRAP != 0) || (row_sum < RW'(FB_HEIGHT));
        row_idx = YW'(row_sum);
        hit     = |(fb[row_idx] & wr_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpu_done      <= 1'b0;
            gpu_collision <= 1'b0;
            gpu_error     <= 1'b0;
            mem_addr      <= '0;
            cnt           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            len_q         <= '0;
            byte_q        <= '0;
            for (int unsigned r = 0; r < FB_HEIGHT; r++)
                fb[YW'(r)] <= '0;
        end else begin
            gpu_done <= done_nx;
            case (state)
                S_IDLE: begin
                    if (gpu_cmd_submitted) begin
                        gpu_collision <= 1'b0;
                        gpu_error     <= (gpu_cmd != CMD_CLEAR) && (gpu_cmd != CMD_DRAW);
                        mem_addr      <= gpu_draw_offset;
                        x_q           <= XW'(gpu_draw_x);
                        y_q           <= YW'(gpu_draw_y);
                        len_q         <= gpu_draw_length;
                        cnt           <= '0;
                    end
                end
                S_CLEAR: begin
                    fb[YW'(cnt)] <= '0;
                    cnt          <= cnt + CNTW'(1);
                end
                S_WAIT: byte_q <= mem_rdata;
                S_WRITE: begin
                    if (row_ok) begin
                        fb[row_idx] <= fb[row_idx] ^ wr_mask;
                        if (hit) gpu_collision <= 1'b1;
                    end
                    cnt      <= cnt + CNTW'(1);
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
